i2c_eeprom_slave: RTL
=====================

# i2c_eeprom_slave

I2C responder that emulates a 24Cxx-style serial EEPROM. It sits on the same SCL/SDA bus as the board's I2C EEPROM master, either in simulation benches or on-chip in place of a physical EEPROM. It implements byte/page writes, current-address reads, random reads and sequential reads from an internal byte array. It also exports a write strobe so benches and system logic can observe every committed byte.

## Interface
Parameters:
- DEV_ID, 4'b1010, fixed upper nibble of the control byte.
- ADDR_BYTES, 2, number of word-address bytes (1 or 2); high byte first.
- MEM_AW, 8, memory address width; depth = 2**MEM_AW bytes; received address is truncated to MEM_AW LSBs.
- PAGE_AW, 4, log2 of page size (16 bytes); PAGE_AW ≤ MEM_AW.

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL frequency (50 MHz vs 400 kHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); the top level ties SDA = sda_oe ? 0 : z.
- dev_addr  in  3  device select bits A2..A0, compared with control byte bits [3:1].
- busy  out  1  high from an address-matched control byte until STOP/START.
- mem_we  out  1  one-cycle strobe per written data byte.
- mem_waddr  out  MEM_AW  address of the byte written; valid with mem_we.
- mem_wdata  out  8  data written; valid with mem_we.
- wr_done  out  1  one-cycle pulse at STOP ending a write carrying ≥1 data byte.

## Operation
- Input conditioning: two-flop synchronizer on scl_in and sda_in, plus one delay register each. Rise/fall are detected on the synchronized values.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are recognized in any state, including mid-byte.
- START (or repeated START): goto CTRL, bit_cnt=0, release SDA, busy=0, pointer kept.
- STOP: goto IDLE, release SDA, busy=0. Pulse wr_done if the transaction wrote ≥1 data byte.
- Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes only in the cycle after a detected SCL fall.
- States: IDLE, CTRL, ADDR, WDATA, RDATA, WAIT_STOP. Each byte state has a 9-bit phase: bit_cnt 0..7 carries data, bit_cnt 8 is the ACK slot.
- CTRL: after 8 bits, match {DEV_ID, dev_addr}.
  - Mismatch: goto WAIT_STOP without ACK.
  - Match: drive ACK (sda_oe=1 from the 8th SCL fall to the 9th SCL fall) and set busy. Then rw=0 goes to ADDR; rw=1 goes to RDATA using the current pointer.
- ADDR: receive ADDR_BYTES bytes, ACK each, and assemble the pointer. Then goto WDATA.
- WDATA: ACK each byte. At the 8th SCL rise, write mem[ptr], pulse mem_we with addr/data, then increment ptr within the page: the low PAGE_AW bits wrap, the upper bits are held.
  - A repeated START after the address phase (random read) keeps ptr.
- RDATA: load mem[ptr] into the shift register. Drive sda_oe = ~bit for bits 7..0 (first bit after the ACK SCL fall), then release at bit_cnt 8 and sample the master's ACK at the 9th SCL rise.
  - ACK (SDA=0): ptr += 1 with full-array wrap; load next byte.
  - NACK: goto WAIT_STOP.
- WAIT_STOP: SDA released; leave only on START or STOP.
- Memory contents are not cleared by reset; ptr resets to 0.

## Timing
- Reset values: sda_oe=0, busy=0, mem_we=0, mem_waddr=0, mem_wdata=0, wr_done=0, state=IDLE, ptr=0.
- Pin-to-detection latency: 3 clk. sda_oe update: 1 clk after detection, i.e. ≤4 clk after the SCL fall pin edge.
- mem_we asserts 1 clk after the 8th rising SCL edge is detected.
- wr_done asserts 1 clk after STOP is detected.
- STOP mid-byte: the partial byte is discarded; no mem_we.
- Reset mid-transfer: all outputs return to reset values immediately; the bus is released.

## Test plan
- Byte write, dev_addr=0: START, 0xA0, 0x00, 0x12, 0xA5, STOP -> four ACKs; mem_we with mem_waddr=0x12, mem_wdata=0xA5; wr_done one cycle after STOP.
- Page wrap: write 18 bytes 0x00..0x11 starting at 0x1E -> mem_waddr sequence 1E,1F,10..1F; final mem[0x1E]=0x10, mem[0x1F]=0x11, mem[0x20] untouched.
- Random + sequential read: address write 0x0012, repeated START, 0xA1, master ACK then NACK, STOP -> bytes 0xA5 then mem[0x13] on SDA; SDA released after NACK.
- Read wrap: current-address read at ptr=0xFF, two ACKed bytes -> mem[0xFF], mem[0x00], mem[0x01].
- Address mismatch: dev_addr=3'b001, control 0xA0 -> sda_oe never asserts, busy stays 0; the next START with 0xA2 is ACKed.
- Aborts: STOP after 4 data bits -> no mem_we, state IDLE. Assert rst_n low during a read bit driving 0 -> sda_oe=0 within the same cycle.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C responder emulating a 24Cxx serial EEPROM with byte/page writes and sequential reads
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_ID     = 4'b1010,
  parameter int         ADDR_BYTES = 2,
  parameter int         MEM_AW     = 8,
  parameter int         PAGE_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [2:0]        dev_addr,
  output logic              busy,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              wr_done
);
  typedef enum logic [2:0] {IDLE, CTRL, ADDR, WDATA, RDATA, WAIT_STOP} state_t;
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_AW) - 1);
  state_t            state_q, state_d;
  logic [2:0]        scl_q, sda_q;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sr_q, sr_d, rx_byte, rd_byte;
  logic [MEM_AW-1:0] ptr_q, ptr_d, page_next, addr_next;
  logic              addr_cnt_q, addr_cnt_d, wrote_q, wrote_d;
  logic              sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic              mem_we_q, mem_we_d, wr_done_q, wr_done_d;
  logic [MEM_AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              scl_rise, scl_fall, start, stop, byte_st, match, last_addr;
  logic [7:0]        mem_q [2**MEM_AW];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start     = scl_q[1] & ~sda_q[1] & sda_q[2];
  assign stop      = scl_q[1] & sda_q[1] & ~sda_q[2];
  assign byte_st   = state_q inside {CTRL, ADDR, WDATA, RDATA};
  assign match     = sr_q[7:1] == {DEV_ID, dev_addr};
  assign last_addr = (ADDR_BYTES == 1) || addr_cnt_q;
  assign rx_byte   = {sr_q[6:0], sda_q[1]};
  assign rd_byte   = mem_q[ptr_q];
  assign page_next = (ptr_q & ~PAGE_MASK) | ((ptr_q + MEM_AW'(1)) & PAGE_MASK);
  assign addr_next = MEM_AW'({ptr_q, sr_q});
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_done   = wr_done_q;
  // Bus sequencing: START/STOP win in any state, then SCL rise samples and SCL fall drives SDA.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    addr_cnt_d  = addr_cnt_q;
    wrote_d     = wrote_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    wr_done_d   = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      wr_done_d = wrote_q;
      wrote_d   = 1'b0;
    end else if (start) begin
      state_d    = CTRL;
      bit_cnt_d  = '0;
      addr_cnt_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else if (byte_st && scl_rise) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (bit_cnt_q < 4'd8 && state_q != RDATA) sr_d = rx_byte;
      if (state_q == WDATA && bit_cnt_q == 4'd7) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = ptr_q;
        mem_wdata_d = rx_byte;
        ptr_d       = page_next;
        wrote_d     = 1'b1;
      end
      if (state_q == RDATA && bit_cnt_q == 4'd8) begin
        state_d = sda_q[1] ? WAIT_STOP : RDATA;
        ptr_d   = sda_q[1] ? ptr_q : ptr_q + MEM_AW'(1);
      end
    end else if (byte_st && scl_fall) begin
      if (bit_cnt_q == 4'd8) begin
        sda_oe_d = state_q != RDATA && (state_q != CTRL || match);
        if (state_q == CTRL) begin
          busy_d  = match;
          state_d = match ? CTRL : WAIT_STOP;
        end
        if (state_q == ADDR) ptr_d = addr_next;
      end else if (bit_cnt_q == 4'd9) begin
        bit_cnt_d = '0;
        sda_oe_d  = 1'b0;
        if (state_q == CTRL) state_d = sr_q[0] ? RDATA : ADDR;
        if (state_q == ADDR) begin
          addr_cnt_d = 1'b1;
          state_d    = last_addr ? WDATA : ADDR;
        end
        if (state_q == RDATA || (state_q == CTRL && sr_q[0])) begin
          sr_d     = rd_byte;
          sda_oe_d = ~rd_byte[7];
        end
      end else if (state_q == RDATA) sda_oe_d = ~sr_q[3'd7 - bit_cnt_q[2:0]];
    end
  end
  // Pin synchronizers, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q       <= '1;
      sda_q       <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      addr_cnt_q  <= 1'b0;
      wrote_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      scl_q       <= {scl_q[1:0], scl_in};
      sda_q       <= {sda_q[1:0], sda_in};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      addr_cnt_q  <= addr_cnt_d;
      wrote_q     <= wrote_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_done_q   <= wr_done_d;
    end
  end
  // Byte array commits the strobed byte; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_q) mem_q[mem_waddr_q] <= mem_wdata_q;
  end
endmodule
